// File: rtl/hex_scan_driver.sv
// Scan controller for an 8-digit common-anode seven-segment display. It shows a
// 32-bit word one nibble at a time, and new words swap in only at frame boundaries.
module hex_scan_driver #(
  parameter int DIV_MAX = 49999,
  parameter int DIV_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic        load,
  input  logic        freeze,
  input  logic        blank_lz,
  output logic [3:0]  num,
  output logic [7:0]  digit_en,
  output logic        blank,
  output logic        load_ack
);

  logic [DIV_W-1:0] cnt;
  logic [2:0]       idx;
  logic [31:0]      disp_buf, pend;
  logic             pend_v, blz_q;
  logic             tick, fb, xfer;
  logic [7:0]       upz;

  assign tick = (cnt == DIV_W'(DIV_MAX));
  assign fb   = tick && (idx == 3'd7);
  assign xfer = fb && pend_v && !freeze;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= '0;
      disp_buf <= '0;
      pend     <= '0;
      pend_v   <= 1'b0;
      load_ack <= 1'b0;
      blz_q    <= 1'b0;
    end else begin
      cnt      <= tick ? '0 : cnt + DIV_W'(1);
      if (tick) idx <= idx + 3'd1;
      load_ack <= xfer;
      blz_q    <= blank_lz;
      if (xfer) disp_buf <= pend;
      // A load in the transfer cycle refills pend, so pend_v must stay set.
      if (load) begin
        pend   <= value;
        pend_v <= 1'b1;
      end else if (xfer) begin
        pend_v <= 1'b0;
      end
    end
  end

  // upz[i]: every nibble from digit i upward is zero.
  assign upz[0] = (disp_buf == '0);
  for (genvar i = 1; i < 8; i++) begin : g_upz
    assign upz[i] = (disp_buf[31:4*i] == '0);
  end

  // Blanking uses a registered copy of blank_lz, so outputs depend only on flops.
  assign num      = disp_buf[{idx, 2'b00} +: 4];
  assign digit_en = ~(8'b1 << idx);
  assign blank    = blz_q && (idx != 3'd0) && upz[idx];

endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed bench for hex_scan_driver with DIV_MAX=3 (dwell 4, frame 32).
module tb_hex_scan_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] value = '0;
  logic        load = 1'b0, freeze = 1'b0, blank_lz = 1'b0;
  logic [3:0]  num;
  logic [7:0]  digit_en;
  logic        blank, load_ack;

  int n_chk = 0, n_fail = 0, acks = 0, pos = 0, a0;

  hex_scan_driver #(.DIV_MAX(3), .DIV_W(2)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .freeze(freeze),
    .blank_lz(blank_lz), .num(num), .digit_en(digit_en), .blank(blank),
    .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    pos = (pos + 1) % 32;
    if (load_ack) acks++;
  endtask

  task automatic run_to(input int p);
    while (pos != p) step();
  endtask

  task automatic pulse_load(input logic [31:0] v);
    load = 1'b1; value = v;
    step();
    load = 1'b0;
  endtask

  // From a frame start: walk all 8 digits, checking the first and last dwell cycle.
  task automatic check_frame(input logic [31:0] w, input logic [7:0] bmask);
    logic [7:0] en;
    for (int k = 0; k < 8; k++) begin
      en = ~(8'b1 << k);
      chk($sformatf("num d%0d", k), {28'b0, num}, {28'b0, w[4*k +: 4]});
      chk($sformatf("en d%0d", k), {24'b0, digit_en}, {24'b0, en});
      chk($sformatf("blank d%0d", k), {31'b0, blank}, {31'b0, bmask[k]});
      repeat (3) step();
      chk($sformatf("num end d%0d", k), {28'b0, num}, {28'b0, w[4*k +: 4]});
      chk($sformatf("en end d%0d", k), {24'b0, digit_en}, {24'b0, en});
      chk($sformatf("ack end d%0d", k), {31'b0, load_ack}, 32'd0);
      step();
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " en"},    {24'b0, digit_en}, 32'hFE);
    chk({tag, " num"},   {28'b0, num},      32'h0);
    chk({tag, " blank"}, {31'b0, blank},    32'h0);
    chk({tag, " ack"},   {31'b0, load_ack}, 32'h0);
  endtask

  initial begin
    // Reset release and scan sequencing
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0; pos = 0; acks = 0;
    chk_reset_outs("rst");
    pulse_load(32'h12345678);
    chk("en pos1", {24'b0, digit_en}, 32'hFE);
    run_to(3);  chk("en pos3", {24'b0, digit_en}, 32'hFE);
    run_to(4);  chk("en pos4", {24'b0, digit_en}, 32'hFD);
    run_to(8);  chk("en pos8", {24'b0, digit_en}, 32'hFB);
    run_to(28); chk("en pos28", {24'b0, digit_en}, 32'h7F);
    chk("no early ack", acks, 0);
    run_to(0);
    chk("ack at 32", {31'b0, load_ack}, 32'd1);
    chk("ack count 1", acks, 1);
    check_frame(32'h12345678, 8'h00);
    chk("single ack", acks, 1);

    // Leading-zero blanking
    blank_lz = 1'b1;
    pulse_load(32'h000000A0);
    run_to(0);
    chk("ack A0", {31'b0, load_ack}, 32'd1);
    check_frame(32'h000000A0, 8'hFC);
    blank_lz = 1'b0;
    check_frame(32'h000000A0, 8'h00);

    // Freeze holds the displayed word
    pulse_load(32'h12345678);
    run_to(0);
    freeze = 1'b1;
    pulse_load(32'hDEADBEEF);
    run_to(0);
    a0 = acks;
    repeat (3) check_frame(32'h12345678, 8'h00);
    chk("frozen no ack", acks, a0);
    freeze = 1'b0;
    repeat (32) step();
    chk("unfreeze ack", {31'b0, load_ack}, 32'd1);
    chk("unfreeze ack count", acks, a0 + 1);
    check_frame(32'hDEADBEEF, 8'h00);

    // Last load wins; load in the transfer cycle
    a0 = acks;
    pulse_load(32'h11111111);
    run_to(10);
    pulse_load(32'h22222222);
    run_to(0);
    chk("coalesced ack", acks, a0 + 1);
    check_frame(32'h22222222, 8'h00);
    pulse_load(32'h44444444);
    run_to(31);
    load = 1'b1; value = 32'h33333333;
    step();
    load = 1'b0;
    chk("xfer ack", {31'b0, load_ack}, 32'd1);
    check_frame(32'h44444444, 8'h00);
    chk("second ack", {31'b0, load_ack}, 32'd1);
    check_frame(32'h33333333, 8'h00);
    chk("ack total", acks, a0 + 3);

    // Reset discards the pending word
    pulse_load(32'h55555555);
    run_to(30);
    rst = 1'b1;
    step();
    rst = 1'b0; pos = 0;
    chk_reset_outs("midrst");
    a0 = acks;
    check_frame(32'h0, 8'h00);
    chk("midrst no ack", {31'b0, load_ack}, 32'd0);
    check_frame(32'h0, 8'h00);
    chk("midrst ack count", acks, a0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
